// File: rtl/sys_io_pkg.sv
// Shared register-map offsets, bit positions and helpers for the sys_io responder.
package sys_io_pkg;

  typedef logic [2:0] ofs_t;

  localparam ofs_t OFS_ID       = 3'd0;
  localparam ofs_t OFS_CYCLE    = 3'd1;
  localparam ofs_t OFS_TMR_CMP  = 3'd2;
  localparam ofs_t OFS_TMR_CTRL = 3'd3;
  localparam ofs_t OFS_TX_DATA  = 3'd4;
  localparam ofs_t OFS_RX_DATA  = 3'd5;
  localparam ofs_t OFS_STATUS   = 3'd6;
  localparam ofs_t OFS_TMR_CNT  = 3'd7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_MATCH  = 8;

  localparam int ST_TX_FULL  = 16;
  localparam int ST_TX_EMPTY = 17;
  localparam int ST_RX_FULL  = 18;
  localparam int ST_RX_EMPTY = 19;
  localparam int ST_TX_OVF   = 24;
  localparam int ST_BUS_ERR  = 25;

  localparam logic [31:0] UNMAPPED_VALUE = 32'hAAAA_AAAA;

  // Offsets that only decode when the compare timer is built in.
  function automatic logic isTimerOfs(input ofs_t ofs);
    return (ofs == OFS_TMR_CMP) || (ofs == OFS_TMR_CTRL) || (ofs == OFS_TMR_CNT);
  endfunction

endpackage

// File: rtl/sys_io_responder_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem[rdPtr_q];
  assign count = count_q;

endmodule

// File: rtl/sys_io_responder.sv
// sys_io_responder: sys_* bus slave with ID, cycle counter, TX/RX byte FIFOs and compare timer.
// The timer (offsets 2/3/7 and irq) is only built when SYS_IO_TIMER_EN is defined.
module sys_io_responder
  import sys_io_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h0000_1000,
  parameter logic [31:0] ID_VALUE = 32'hC0DE_0032,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sys_r_addr,
  input  logic        sys_r,
  input  logic [31:0] sys_w_addr,
  input  logic [31:0] sys_w_line,
  input  logic        sys_w,
  output logic [31:0] sys_r_line,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  logic [31:0]      rDiff, wDiff;
  ofs_t             rOfs, wOfs;
  logic             rValid, wValid;
  logic             txWr, statusWr, rxRd;
  logic             txPush, txPop, rxPush, rxPop;
  logic             txFull, txEmpty, rxFull, rxEmpty;
  logic [TX_CW-1:0] txCount;
  logic [RX_CW-1:0] rxCount;
  logic [7:0]       rxHead;
  logic [31:0]      statusWord;
  logic [31:0]      cycle_q;
  logic             txOvf_q, txOvf_d, busErr_q, busErr_d;

  assign rDiff = sys_r_addr - BASE;
  assign wDiff = sys_w_addr - BASE;
  assign rOfs  = rDiff[2:0];
  assign wOfs  = wDiff[2:0];

`ifdef SYS_IO_TIMER_EN
  assign rValid = (rDiff < 32'd8);
  assign wValid = (wDiff < 32'd8);
`else
  assign rValid = (rDiff < 32'd8) && !isTimerOfs(rOfs);
  assign wValid = (wDiff < 32'd8) && !isTimerOfs(wOfs);
`endif

  assign txWr     = sys_w && wValid && (wOfs == OFS_TX_DATA);
  assign statusWr = sys_w && wValid && (wOfs == OFS_STATUS);
  assign rxRd     = sys_r && rValid && (rOfs == OFS_RX_DATA);

  // A push into a full TX FIFO is lost even if the consumer pops in the same cycle.
  assign txPush   = txWr && !txFull;
  assign txPop    = !txEmpty && tx_ready;
  assign tx_valid = !txEmpty;
  assign rx_ready = rst && !rxFull;
  assign rxPush   = rx_valid && rx_ready;
  assign rxPop    = rxRd && !rxEmpty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txFifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (txPush),
    .pop   (txPop),
    .din   (sys_w_line[7:0]),
    .dout  (tx_data),
    .full  (txFull),
    .empty (txEmpty),
    .count (txCount)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rxFifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (rxPush),
    .pop   (rxPop),
    .din   (rx_data),
    .dout  (rxHead),
    .full  (rxFull),
    .empty (rxEmpty),
    .count (rxCount)
  );

  // Sticky flags: a hardware set in the same cycle beats a write-1-to-clear.
  always_comb begin
    txOvf_d  = txOvf_q;
    busErr_d = busErr_q;
    if (statusWr && sys_w_line[ST_TX_OVF])  txOvf_d  = 1'b0;
    if (statusWr && sys_w_line[ST_BUS_ERR]) busErr_d = 1'b0;
    if (txWr && txFull) txOvf_d = 1'b1;
    if ((sys_r && !rValid) || (sys_w && !wValid)) busErr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q  <= '0;
      txOvf_q  <= 1'b0;
      busErr_q <= 1'b0;
    end else begin
      cycle_q  <= cycle_q + 32'd1;
      txOvf_q  <= txOvf_d;
      busErr_q <= busErr_d;
    end
  end

  always_comb begin
    statusWord              = '0;
    statusWord[7:0]         = 8'(txCount);
    statusWord[15:8]        = 8'(rxCount);
    statusWord[ST_TX_FULL]  = txFull;
    statusWord[ST_TX_EMPTY] = txEmpty;
    statusWord[ST_RX_FULL]  = rxFull;
    statusWord[ST_RX_EMPTY] = rxEmpty;
    statusWord[ST_TX_OVF]   = txOvf_q;
    statusWord[ST_BUS_ERR]  = busErr_q;
  end

`ifdef SYS_IO_TIMER_EN
  logic [31:0] tmrCnt_q, tmrCnt_d, tmrCmp_q, tmrCmp_d, ctrlWord;
  logic        en_q, en_d, autoReload_q, autoReload_d, irqEn_q, irqEn_d, match_q, match_d;
  logic        cmpWr, ctrlWr, cntWr, tmrHit;

  assign cmpWr  = sys_w && wValid && (wOfs == OFS_TMR_CMP);
  assign ctrlWr = sys_w && wValid && (wOfs == OFS_TMR_CTRL);
  assign cntWr  = sys_w && wValid && (wOfs == OFS_TMR_CNT);
  assign tmrHit = en_q && (tmrCnt_q == tmrCmp_q);

  // Bus writes override the timer's own update, except the match clear loses to a new hit.
  always_comb begin
    tmrCnt_d     = tmrCnt_q;
    tmrCmp_d     = tmrCmp_q;
    en_d         = en_q;
    autoReload_d = autoReload_q;
    irqEn_d      = irqEn_q;
    match_d      = match_q;
    if (tmrHit) begin
      match_d = 1'b1;
      if (autoReload_q) tmrCnt_d = '0;
      else              en_d     = 1'b0;
    end else if (en_q) begin
      tmrCnt_d = tmrCnt_q + 32'd1;
    end
    if (ctrlWr && sys_w_line[CTRL_MATCH] && !tmrHit) match_d = 1'b0;
    if (cmpWr) tmrCmp_d = sys_w_line;
    if (ctrlWr) begin
      en_d         = sys_w_line[CTRL_EN];
      autoReload_d = sys_w_line[CTRL_AUTO];
      irqEn_d      = sys_w_line[CTRL_IRQ_EN];
    end
    if (cntWr) tmrCnt_d = sys_w_line;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmrCnt_q     <= '0;
      tmrCmp_q     <= 32'hFFFF_FFFF;
      en_q         <= 1'b0;
      autoReload_q <= 1'b0;
      irqEn_q      <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      tmrCnt_q     <= tmrCnt_d;
      tmrCmp_q     <= tmrCmp_d;
      en_q         <= en_d;
      autoReload_q <= autoReload_d;
      irqEn_q      <= irqEn_d;
      match_q      <= match_d;
    end
  end

  always_comb begin
    ctrlWord              = '0;
    ctrlWord[CTRL_EN]     = en_q;
    ctrlWord[CTRL_AUTO]   = autoReload_q;
    ctrlWord[CTRL_IRQ_EN] = irqEn_q;
    ctrlWord[CTRL_MATCH]  = match_q;
  end

  assign irq = match_q && irqEn_q;
`else
  logic unusedWriteBits;
  assign unusedWriteBits = ^{sys_w_line[31:26], sys_w_line[23:8]};
  assign irq = 1'b0;
`endif

  // Read data is purely combinational so the initiator samples it alongside sys_r.
  always_comb begin
    sys_r_line = UNMAPPED_VALUE;
    if (rValid) begin
      case (rOfs)
        OFS_ID:       sys_r_line = ID_VALUE;
        OFS_CYCLE:    sys_r_line = cycle_q;
        OFS_TX_DATA:  sys_r_line = '0;
        OFS_RX_DATA:  sys_r_line = rxEmpty ? 32'd0 : {1'b1, 23'd0, rxHead};
        OFS_STATUS:   sys_r_line = statusWord;
`ifdef SYS_IO_TIMER_EN
        OFS_TMR_CMP:  sys_r_line = tmrCmp_q;
        OFS_TMR_CTRL: sys_r_line = ctrlWord;
        OFS_TMR_CNT:  sys_r_line = tmrCnt_q;
`endif
        default:      sys_r_line = UNMAPPED_VALUE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_io_responder.sv
// Self-checking bench for sys_io_responder: directed register-map steps plus randomized
// FIFO/bus traffic against a queue-based model. Timer steps run only with SYS_IO_TIMER_EN.
module tb_sys_io_responder;
  localparam logic [31:0] BASE     = 32'h0000_1000;
  localparam logic [31:0] ID_VALUE = 32'hC0DE_0032;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] sys_r_addr = '0, sys_w_addr = '0, sys_w_line = '0;
  logic        sys_r = 1'b0, sys_w = 1'b0;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [31:0] sys_r_line;
  logic [7:0]  tx_data;
  logic        tx_valid, rx_ready, irq;

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;
  int unsigned edges = 0;
  logic txr = 1'b0;
  bit timerActive = 1'b0;

  // Reference model: FIFOs as queues, sticky flags as bits, CYCLE as edges since reset.
  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];
  bit mOvf = 1'b0;
  bit mBusErr = 1'b0;

  sys_io_responder #(
    .BASE(BASE), .ID_VALUE(ID_VALUE), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .sys_r_addr(sys_r_addr), .sys_r(sys_r),
    .sys_w_addr(sys_w_addr), .sys_w_line(sys_w_line), .sys_w(sys_w),
    .sys_r_line(sys_r_line),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= rst ? edges + 1 : 0;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit modelMapped(input logic [31:0] addr);
    logic [31:0] ofs;
    ofs = addr - BASE;
    if (ofs > 32'd7) return 1'b0;
`ifndef SYS_IO_TIMER_EN
    if (ofs == 32'd2 || ofs == 32'd3 || ofs == 32'd7) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] statusWord();
    logic [31:0] s;
    s = '0;
    s[7:0]  = 8'(txQ.size());
    s[15:8] = 8'(rxQ.size());
    s[16]   = (txQ.size() == DEPTH);
    s[17]   = (txQ.size() == 0);
    s[18]   = (rxQ.size() == DEPTH);
    s[19]   = (rxQ.size() == 0);
    s[24]   = mOvf;
    s[25]   = mBusErr;
    return s;
  endfunction

  // Timer registers are never routed here; timer reads supply their own expectation.
  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    logic [31:0] ofs;
    if (!modelMapped(addr)) return 32'hAAAA_AAAA;
    ofs = addr - BASE;
    case (ofs)
      32'd0:   return ID_VALUE;
      32'd1:   return edges;
      32'd5:   return (rxQ.size() > 0) ? {1'b1, 23'd0, rxQ[0]} : 32'd0;
      32'd6:   return statusWord();
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelUpdate(input logic r, input logic [31:0] ra, input logic w,
                             input logic [31:0] wa, input logic [31:0] wd,
                             input logic rxv, input logic [7:0] rxd);
    bit txFullPre, rxReadyPre, errSet, ovfSet;
    logic [7:0] dropped;
    txFullPre  = (txQ.size() == DEPTH);
    rxReadyPre = (rxQ.size() < DEPTH);
    errSet     = (r && !modelMapped(ra)) || (w && !modelMapped(wa));
    ovfSet     = w && (wa == BASE + 4) && txFullPre;
    if (txQ.size() > 0 && txr) dropped = txQ.pop_front();
    if (w && wa == BASE + 4 && !txFullPre) txQ.push_back(wd[7:0]);
    if (r && ra == BASE + 5 && rxQ.size() > 0) dropped = rxQ.pop_front();
    if (rxv && rxReadyPre) rxQ.push_back(rxd);
    if (ovfSet) mOvf = 1'b1;
    else if (w && wa == BASE + 6 && wd[24]) mOvf = 1'b0;
    if (errSet) mBusErr = 1'b1;
    else if (w && wa == BASE + 6 && wd[25]) mBusErr = 1'b0;
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] ra, input logic w,
                               input logic [31:0] wa, input logic [31:0] wd,
                               input logic rxv, input logic [7:0] rxd);
    sys_r = r; sys_r_addr = ra;
    sys_w = w; sys_w_addr = wa; sys_w_line = wd;
    rx_valid = rxv; rx_data = rxd;
    tx_ready = txr;
  endtask

  // One bus cycle: drive, check pre-edge outputs against the model, advance model and clock.
  task automatic busCycle(input logic r, input logic [31:0] ra, input logic w,
                          input logic [31:0] wa, input logic [31:0] wd,
                          input logic rxv, input logic [7:0] rxd,
                          input bit useExp, input logic [31:0] expData);
    applyStimulus(r, ra, w, wa, wd, rxv, rxd);
    #1;
    if (r) checkOutput($sformatf("rdata@%h", ra), sys_r_line, useExp ? expData : modelRead(ra));
    checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, txQ.size() > 0});
    if (txQ.size() > 0) checkOutput("tx_data", {24'd0, tx_data}, {24'd0, txQ[0]});
    checkOutput("rx_ready", {31'd0, rx_ready}, {31'd0, rxQ.size() < DEPTH});
    if (!timerActive) checkOutput("irq", {31'd0, irq}, 32'd0);
    modelUpdate(r, ra, w, wa, wd, rxv, rxd);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    busCycle(1'b1, a, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    busCycle(1'b0, '0, 1'b1, a, d, 1'b0, '0, 1'b0, '0);
  endtask

  function automatic logic [31:0] pickReadAddr(input int idx);
    case (idx)
      0: return BASE;
      1: return BASE + 1;
      2: return BASE + 4;
      3: return BASE + 5;
      4: return BASE + 5;
      5: return BASE + 6;
      6: return BASE - 1;
      default: return 32'h8000_0000 | 32'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pickWriteAddr(input int idx);
    case (idx)
      0, 1, 2: return BASE + 4;
      3:       return BASE + 6;
      4:       return BASE + 5;
      5:       return BASE;
      6:       return BASE + 8;
      default: return 32'h8000_0000 | 32'($urandom);
    endcase
  endfunction

  initial begin
    logic        r, w, rxv;
    logic [31:0] ra, wa, wd;
    logic [7:0]  rxd;

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    #1;
    sys_r = 1'b1; sys_r_addr = BASE + 6;
    #1;
    checkOutput("reset status", sys_r_line, 32'h000A_0000);
    checkOutput("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("reset rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("reset irq", {31'd0, irq}, 32'd0);
    sys_r = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ID then consecutive CYCLE reads, unmapped read sets bus_err.
    rd(BASE);
    rd(BASE + 1);
    rd(BASE + 1);
    rd(32'h0000_0FFF);
    rd(BASE + 6);
`ifndef SYS_IO_TIMER_EN
    rd(BASE + 2);
    rd(BASE + 3);
    wr(BASE + 7, 32'h1234_5678);
    rd(BASE + 7);
`endif

    // Same-cycle STATUS read and bus_err clear: read sees the flag, the next read does not.
    busCycle(1'b1, BASE + 6, 1'b1, BASE + 6, 32'h0200_0000, 1'b0, '0, 1'b0, '0);
    rd(BASE + 6);

    // TX overflow with the consumer stalled, then drain.
    txr = 1'b0;
    for (int i = 0; i < 5; i++) wr(BASE + 4, 32'h41 + 32'(i));
    rd(BASE + 6);
    txr = 1'b1;
    for (int i = 0; i < 6; i++) rd(BASE + 6);
    wr(BASE + 6, 32'h0100_0000);
    rd(BASE + 6);

    // RX: two bytes in, three pops (last one on empty).
    txr = 1'b0;
    busCycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 8'h10, 1'b0, '0);
    busCycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 8'h20, 1'b0, '0);
    busCycle(1'b1, BASE + 5, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h8000_0010);
    busCycle(1'b1, BASE + 5, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h8000_0020);
    busCycle(1'b1, BASE + 5, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h0000_0000);
    rd(BASE + 6);

    // Randomized mix of bus accesses, consumer back-pressure and incoming bytes.
    for (int i = 0; i < 300; i++) begin
      r   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      ra  = pickReadAddr(int'($urandom_range(0, 7)));
      wa  = pickWriteAddr(int'($urandom_range(0, 7)));
      wd  = 32'($urandom);
      rxv = 1'($urandom_range(0, 1));
      rxd = 8'($urandom);
      txr = ($urandom_range(0, 3) == 0);
      busCycle(r, ra, w, wa, wd, rxv, rxd, 1'b0, '0);
    end
    txr = 1'b0;

`ifdef SYS_IO_TIMER_EN
    // Compare timer: CMP=5 with auto-reload hits every 6 edges after the enabling write.
    timerActive = 1'b1;
    wr(BASE + 2, 32'd5);
    busCycle(1'b1, BASE + 2, 1'b1, BASE + 3, 32'h7, 1'b0, '0, 1'b1, 32'd5);
    for (int k = 1; k <= 20; k++) begin
      int  n;
      bit  mExp;
      bit  clr;
      n    = k - 1;
      mExp = (n >= 6) && !(n >= 7 && n <= 11) && !(n >= 13 && n <= 17);
      clr  = (k == 7) || (k == 13) || (k == 18);
      checkOutput($sformatf("irq n=%0d", n), {31'd0, irq}, {31'd0, mExp});
      busCycle(1'b1, BASE + 7, clr, BASE + 3, 32'h107, 1'b0, '0, 1'b1, 32'(n % 6));
    end
    busCycle(1'b1, BASE + 3, 1'b0, '0, '0, 1'b0, '0, 1'b1, 32'h107);
`endif

    // Reset mid-operation with both FIFOs holding data.
    wr(BASE + 4, 32'h55);
    wr(BASE + 4, 32'h66);
    busCycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 8'h77, 1'b0, '0);
    rst = 1'b0;
    sys_w = 1'b0; rx_valid = 1'b0;
    sys_r = 1'b1; sys_r_addr = BASE + 6;
    #1;
    checkOutput("mid-reset status", sys_r_line, 32'h000A_0000);
    checkOutput("mid-reset tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("mid-reset rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("mid-reset irq", {31'd0, irq}, 32'd0);
    sys_r_addr = BASE + 1;
    #1;
    checkOutput("mid-reset cycle", sys_r_line, 32'd0);
    txQ.delete();
    rxQ.delete();
    mOvf = 1'b0;
    mBusErr = 1'b0;
    timerActive = 1'b0;
    sys_r = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd(BASE + 1);
    rd(BASE + 1);
    rd(BASE + 6);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
